// File: rtl/seg_decoder.sv
// seg_decoder: debounces a sampled 7-segment pattern and decodes it into a
// signed 4-bit value, queueing each accepted result for a downstream consumer.
//
// Ports
//   clk_2      : clock, all state changes on its rising edge
//   reset      : asynchronous active-high reset
//   SEG_IN     : bit 7 minus sign, bits 6:0 segments g..a
//   seg_valid  : SEG_IN is sampled only when high
//   out_ready  : consumer accepts the queue head
//   out_valid  : queue non-empty
//   out_value  : two's-complement value at queue head (0 when empty)
//   out_error  : queue head is an error entry (0 when empty)
//   err_count  : accepted error patterns, saturating at 255
//   LED        : {last accept was error, overflow, full, empty, last value}
module seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [7:0] SEG_IN,
  input  logic       seg_valid,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_value,
  output logic       out_error,
  output logic [7:0] err_count,
  output logic [7:0] LED
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

  state_e       state_q, state_d;
  logic [7:0]   cand_q, cand_d;
  logic [3:0]   run_q, run_d;
  logic         accept;

  logic         dec_err;
  logic [3:0]   dec_val;

  logic [4:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q;
  logic             full, empty, push, pop;
  logic             ovf_q;
  logic [7:0]       errc_q;
  logic [3:0]       last_val_q;
  logic             last_err_q;
  logic [4:0]       head;

  // Filter FSM: a differing sample restarts the run; LOCKED swallows repeats.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    accept  = 1'b0;
    if (seg_valid) begin
      if (state_q == IDLE || SEG_IN != cand_q) begin
        cand_d = SEG_IN;
        run_d  = 4'd1;
        if (STABLE_CYCLES == 1) begin
          state_d = LOCKED;
          accept  = 1'b1;
        end else begin
          state_d = TRACK;
        end
      end else if (state_q == TRACK) begin
        run_d = run_q + 4'd1;
        if (run_d == 4'(STABLE_CYCLES)) begin
          state_d = LOCKED;
          accept  = 1'b1;
        end
      end
    end
  end

  // Accept only happens on a cycle where SEG_IN equals the candidate,
  // so decoding SEG_IN directly avoids a second decoder on cand_q.
  always_comb begin
    dec_err = 1'b0;
    dec_val = '0;
    case (SEG_IN)
      8'b0011_1111: dec_val = 4'd0;
      8'b0000_0110: dec_val = 4'd1;
      8'b0101_1011: dec_val = 4'd2;
      8'b0100_1111: dec_val = 4'd3;
      8'b1000_0110: dec_val = 4'hF;
      8'b1101_1011: dec_val = 4'hE;
      8'b1100_1111: dec_val = 4'hD;
      8'b1110_0110: dec_val = 4'hC;
      default:      dec_err = 1'b1;
    endcase
  end

  assign full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && out_ready;
  // When full, a same-edge pop frees the slot the new entry goes into.
  assign push  = accept && (!full || pop);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      run_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      errc_q     <= '0;
      last_val_q <= '0;
      last_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PTR_W+1)'(1);
      if (accept && !push) ovf_q <= 1'b1;
      if (accept) begin
        last_val_q <= dec_val;
        last_err_q <= dec_err;
        if (dec_err && errc_q != 8'hFF) errc_q <= errc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (push) mem[wr_q] <= {dec_err, dec_val};
  end

  assign head      = mem[rd_q];
  assign out_valid = !empty;
  assign out_value = empty ? '0 : head[3:0];
  assign out_error = empty ? 1'b0 : head[4];
  assign err_count = errc_q;
  assign LED       = {last_err_q, ovf_q, full, empty, last_val_q};

endmodule

// File: tb/tb_seg_decoder.sv
module tb_seg_decoder;

  localparam int unsigned SC = 3;
  localparam int unsigned D  = 4;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] SEG_IN;
  logic       seg_valid;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_value;
  logic       out_error;
  logic [7:0] err_count;
  logic [7:0] LED;

  seg_decoder #(.STABLE_CYCLES(SC), .FIFO_DEPTH(D)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .SEG_IN    (SEG_IN),
    .seg_valid (seg_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_error (out_error),
    .err_count (err_count),
    .LED       (LED)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a run is the number of consecutive identical valid
  // samples; a pattern is accepted exactly when its run reaches SC.
  logic [7:0] pats [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h86, 8'hDB, 8'hCF, 8'hE6};
  int         vals [8] = '{0, 1, 2, 3, -1, -2, -3, -4};

  logic [4:0] q [$];
  int         prev_seg;
  int         run_len;
  bit         m_ovf;
  int         m_errc;
  logic [3:0] m_last_val;
  bit         m_last_err;

  function automatic void decode(input logic [7:0] p, output bit err, output logic [3:0] v);
    err = 1'b1;
    v   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (pats[i] == p) begin
        err = 1'b0;
        v   = 4'(vals[i]);
      end
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    prev_seg   = -1;
    run_len    = 0;
    m_ovf      = 1'b0;
    m_errc     = 0;
    m_last_val = 4'd0;
    m_last_err = 1'b0;
  endfunction

  function automatic void model_edge();
    bit         do_pop;
    bit         acc;
    bit         e;
    logic [3:0] v;
    do_pop = (q.size() > 0) && out_ready;
    acc    = 1'b0;
    if (seg_valid) begin
      if (prev_seg == int'(SEG_IN)) run_len++;
      else run_len = 1;
      prev_seg = int'(SEG_IN);
      acc = (run_len == SC);
    end
    if (do_pop) void'(q.pop_front());
    if (acc) begin
      decode(SEG_IN, e, v);
      if (e && m_errc < 255) m_errc++;
      m_last_val = v;
      m_last_err = e;
      if (q.size() < D) q.push_back({e, v});
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic compare(input string tag);
    logic [4:0] h;
    h = (q.size() > 0) ? q[0] : 5'd0;
    check({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".value"}, 32'(out_value), 32'(h[3:0]));
    check({tag, ".error"}, 32'(out_error), 32'(h[4]));
    check({tag, ".errcnt"}, 32'(err_count), 32'(m_errc));
    check({tag, ".led"}, 32'(LED),
          32'({m_last_err, m_ovf, q.size() == D, q.size() == 0, m_last_val}));
  endtask

  task automatic cycle(input string tag, input logic v, input logic [7:0] s, input logic r);
    seg_valid = v;
    SEG_IN    = s;
    out_ready = r;
    @(posedge clk_2);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < D + 1; i++) cycle(tag, 1'b0, 8'h00, 1'b1);
  endtask

  logic [7:0] pool [6] = '{8'h3F, 8'h4F, 8'hE6, 8'h80, 8'h77, 8'hDB};
  logic [7:0] cur;

  initial begin
    reset     = 1'b1;
    SEG_IN    = 8'h00;
    seg_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check("rst.led", 32'(LED), 32'h10);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.errcnt", 32'(err_count), 32'd0);
    reset = 1'b0;
    compare("rst");

    // Three samples of 3 -> one entry; three more -> nothing new.
    for (int i = 0; i < 6; i++) cycle("s028", 1'b1, 8'h4F, 1'b0);
    check("s028.head", 32'(out_value), 32'd3);
    drain("s028d");

    // -4 seen only twice, then 1 three times.
    for (int i = 0; i < 2; i++) cycle("s029a", 1'b1, 8'hE6, 1'b0);
    for (int i = 0; i < 3; i++) cycle("s029b", 1'b1, 8'h06, 1'b0);
    check("s029.head", 32'(out_value), 32'd1);
    drain("s029d");

    // Two distinct error patterns.
    for (int i = 0; i < 3; i++) cycle("s030a", 1'b1, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) cycle("s030b", 1'b1, 8'h77, 1'b0);
    check("s030.errcnt", 32'(err_count), 32'd2);
    check("s030.led7", 32'(LED[7]), 32'd1);
    drain("s030d");

    // Fill, overflow, then push coinciding with pop while full.
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 3; i++) cycle("s031f", 1'b1, pats[p], 1'b0);
    check("s031.ovf", 32'(LED[6]), 32'd1);
    check("s031.full", 32'(LED[5]), 32'd1);
    cycle("s031p", 1'b1, 8'hDB, 1'b0);
    cycle("s031p", 1'b1, 8'hDB, 1'b0);
    cycle("s031p", 1'b1, 8'hDB, 1'b1);
    check("s031.fullpp", 32'(LED[5]), 32'd1);
    drain("s031d");

    // Valid gaps mid-run.
    for (int i = 0; i < 5; i++) cycle("s032", (i % 2) == 0, 8'h5B, 1'b0);
    check("s032.valid", 32'(out_valid), 32'd1);
    drain("s032d");

    // Reset between edges with two entries queued and a run in progress.
    for (int i = 0; i < 3; i++) cycle("s033a", 1'b1, 8'hCF, 1'b0);
    for (int i = 0; i < 3; i++) cycle("s033a", 1'b1, 8'h06, 1'b0);
    for (int i = 0; i < 2; i++) cycle("s033b", 1'b1, 8'h5B, 1'b0);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("s033.led", 32'(LED), 32'h10);
    compare("s033r");
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle("s033c", 1'b1, 8'h5B, 1'b0);
    drain("s033d");

    // Randomized run over a small pattern pool to get both runs and breaks.
    cur = pool[0];
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cur = pool[$urandom_range(0, 5)];
      cycle("rand", $urandom_range(0, 3) != 0, cur, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_decoder.md
SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3: identical consecutive samples required to accept a pattern (legal range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: decoded-result queue depth (power of two, 2..8).
REQ-003 SHALL have port clk_2, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port SEG_IN, input, 8 bits: sampled 7-segment pattern; bit 7 is the minus sign, bits 6:0 are segments g..a.
REQ-006 SHALL have port seg_valid, input, 1 bit: SEG_IN is sampled on a cycle only when this is high.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts the queue head.
REQ-008 SHALL have port out_valid, output, 1 bit: queue non-empty.
REQ-009 SHALL have port out_value, output, 4 bits: signed two's-complement value at queue head.
REQ-010 SHALL have port out_error, output, 1 bit: queue head is an error entry.
REQ-011 SHALL have port err_count, output, 8 bits: accepted error patterns, saturating.
REQ-012 SHALL have port LED, output, 8 bits: status display.

Function
REQ-013 SHALL decode patterns as follows: 00111111->0; 00000110->1; 01011011->2; 01001111->3; 10000110->-1; 11011011->-2; 11001111->-3; 11100110->-4; any other pattern, including 10000000, ->error with value 0000.
REQ-014 SHALL run a filter FSM with states IDLE (no candidate), TRACK (counting), and LOCKED (candidate accepted).
REQ-015 SHALL, on a cycle with seg_valid=0, hold state, candidate, and run counter unchanged.
REQ-016 SHALL, on seg_valid=1 with SEG_IN differing from the candidate (or in IDLE), load the candidate with SEG_IN, set the run counter to 1, and enter TRACK; if STABLE_CYCLES=1, it SHALL instead accept immediately and enter LOCKED.
REQ-017 SHALL, on seg_valid=1 with SEG_IN equal to the candidate in TRACK, increment the run counter; when the counter reaches STABLE_CYCLES, it SHALL accept the candidate on that edge and enter LOCKED.
REQ-018 SHALL, in LOCKED, ignore repeated identical samples (no re-accept) and return to TRACK only on a differing sample, per REQ-016.
REQ-019 SHALL, on accept, push {error flag, value} into the FIFO on the same edge, so out_valid is high in the following cycle; there is no combinational bypass.
REQ-020 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-021 SHALL drop an accept that arrives while the FIFO is full and no pop occurs on that edge, and SHALL set a sticky overflow flag.
REQ-022 SHALL, on simultaneous push and pop when full, perform both, leaving the count unchanged with the new entry at the tail.
REQ-023 SHALL drive out_value=0000 and out_error=0 when the FIFO is empty; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 SHALL increment err_count on each accepted error pattern, whether or not the push is dropped, saturating at 255.
REQ-025 SHALL drive LED[3:0] with the last accepted value, LED[4] high when the FIFO is empty, LED[5] high when the FIFO is full, LED[6] with the overflow flag, and LED[7] high when the last accept was an error.

Reset
REQ-026 SHALL, while reset is high and irrespective of clk_2, force state IDLE, run counter 0, candidate 0, FIFO empty, overflow 0, err_count 0, LED=00010000, out_valid 0, out_value 0, and out_error 0.
REQ-027 SHALL, when reset is asserted mid-TRACK or with the FIFO non-empty, discard all partial and queued data; the first sample after reset SHALL start a new run.

Verification
REQ-028 SHALL cover: SEG_IN=01001111 with seg_valid high for 3 cycles -> one accept, out_valid next cycle, out_value=0011, out_error=0; 3 further identical samples -> no new entry.
REQ-029 SHALL cover: 11100110 for 2 cycles, then 00000110 for 3 cycles -> exactly one entry, value 0001; the -4 pattern is never accepted.
REQ-030 SHALL cover: 10000000 stable for 3 cycles, then 01110111 stable for 3 cycles -> two error entries, err_count=2, LED[7]=1.
REQ-031 SHALL cover: out_ready=0 and 5 distinct accepted patterns -> 4 entries in FIFO order, the 5th dropped, LED[6]=1, LED[5]=1; a push coinciding with a pop while full -> count stays 4.
REQ-032 SHALL cover: seg_valid gaps mid-run (valid, idle, valid, idle, valid on the same pattern) -> accept on the 3rd valid sample.
REQ-033 SHALL cover: reset pulse asserted between clock edges while 2 entries are queued -> outputs clear immediately with LED=00010000, and the next accept needs a full 3-sample run.
